board_game_sequencer: RTL and testbench
=======================================

// Module: board_game_sequencer
// PURPOSE
//  Tic-tac-toe game controller for the 3x3 cell grid drawn by the VGA pixel path.
//  Holds board and cursor state and sequences turns from button pulses.
//  Detects win/draw. Publishes a display copy of the board, updated only at frame start, so the renderer never tears mid-frame.
//  Sits between input conditioning (debounced one-cycle pulses) and the VGA colour/text generator.
// PARAMETERS
//  FIRST_PLAYER    1    player owning the first turn after reset/restart (1 or 2)
//  TIMEOUT_FRAMES  600  frames without a select before the turn passes (0 = disabled)
//  CNT_W           10   width of the frame-timeout counter; must hold TIMEOUT_FRAMES
// PORTS
//  clk_25Mhz     in   1   pixel clock, same domain as the VGA H/V counters
//  rst           in   1   async, active-high reset
//  btn_move      in   1   one-cycle pulse: advance cursor
//  btn_select    in   1   one-cycle pulse: claim cursor cell / start / restart
//  frame_start   in   1   one-cycle pulse when the V counter wraps to 0
//  disp_cells    out  18  display board, 2b per cell, cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2
//  disp_cursor   out  4   display cursor index 0..8 (row-major, 0 = top-left)
//  disp_turn     out  2   display: player to move (01/10), 00 when not in TURN
//  game_over     out  1   high in WIN or DRAW (live, not frame-aligned)
//  winner        out  2   01 P1, 10 P2, 11 draw, 00 none (live)
// BEHAVIOUR
//  Reset: board all 00, cursor 0, turn=FIRST_PLAYER, timeout cnt 0, state IDLE.
//    All disp_* = 0; game_over=0; winner=00.
//  FSM states: IDLE, TURN, CHECK, WIN, DRAW.
//   IDLE : btn_select -> TURN. Board already clear.
//   TURN : btn_move -> cursor=(cursor==8)?0:cursor+1.
//          btn_select on empty cell -> write cell=turn, -> CHECK.
//          btn_select on occupied cell -> ignored, stay TURN.
//          btn_select and btn_move in same cycle -> select wins, move dropped.
//   CHECK: one cycle. 3-in-a-row for turn -> WIN.
//          Else all 9 cells non-empty -> DRAW.
//          Else toggle turn, clear timeout cnt -> TURN.
//   WIN/DRAW: board frozen; move ignored. btn_select -> clear board, cursor 0,
//          turn=FIRST_PLAYER, cnt 0 -> TURN (one cycle).
//  Latency: select accepted in cycle N -> cell written at N+1 (state CHECK);
//    winner/game_over or toggled turn valid at N+2.
//  Timeout: in TURN, cnt increments on each frame_start.
//    When cnt==TIMEOUT_FRAMES-1 and frame_start -> toggle turn, cnt 0; no cell written.
//    Any accepted select clears cnt. cnt holds its value outside TURN.
//    With TIMEOUT_FRAMES=0 the counter never runs.
//  Display copy: disp_cells/disp_cursor/disp_turn load from live state only on
//    frame_start; they hold otherwise.
//    frame_start coinciding with a write loads the pre-write value; the new cell shows next frame.
//  winner encoding 11 only in DRAW. WIN never coexists with a full-board draw (win has priority).
//  rst mid-game: immediate return to reset values, including display regs; no partial frame.
//  Inputs assumed synchronous to clk_25Mhz; no internal debounce.
// STRUCTURE
//  Package board_pkg:
//    typedef enum logic[1:0] cell_t {EMPTY, P1, P2}
//    typedef enum state_t
//    localparam WIN_LINES[8][3] cell index triples
//    localparam NUM_CELLS=9
//  Sub-module win_detector (combinational): in 18b board + cell_t player;
//    out line_hit, board_full.
//  Top holds FSM, board regs, cursor, turn, timeout counter, display shadow regs.
// TESTING
//  1 rst, select, then selects at cells 0,3,1,4,2 (moves between) -> winner=01, game_over=1 two cycles after last select.
//  2 Fill P1:0,2,3,7,8 / P2:1,4,5,6 in play order -> DRAW, winner=11.
//  3 Select an occupied cell -> board unchanged, turn unchanged, state TURN.
//  4 Cursor at 8 + btn_move -> cursor 0.
//    Move+select same cycle at cursor 5 -> cell 5 claimed, cursor stays 5.
//  5 Write cell 4, observe disp_cells: unchanged until next frame_start, then bits[9:8]=01.
//    frame_start same cycle as write -> shows next frame.
//  6 TIMEOUT_FRAMES=3, no select for 3 frame_start pulses -> turn toggles, board unchanged.
//    Assert rst mid-game -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared cell/state types and the winning-line table for the tic-tac-toe sequencer.
package board_pkg;
   typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
   typedef enum logic [2:0] {IDLE, TURN, CHECK, WIN, DRAW} state_t;
   localparam int NUM_CELLS = 9;
   localparam logic [7:0][2:0][3:0] WIN_LINES = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };
endpackage

// File: rtl/win_detector.sv
// win_detector: flags a completed line for one player and a board with no empty cell.
module win_detector
   import board_pkg::*;
(
   input  logic [2*NUM_CELLS-1:0] cells_i,
   input  cell_t                  player_i,
   output logic                   line_hit_o,
   output logic                   board_full_o
);
   always_comb begin
      line_hit_o   = 1'b0;
      board_full_o = 1'b1;
      for (int l = 0; l < 8; l++)
         line_hit_o |= (cells_i[2*WIN_LINES[l][0] +: 2] == player_i) &&
                       (cells_i[2*WIN_LINES[l][1] +: 2] == player_i) &&
                       (cells_i[2*WIN_LINES[l][2] +: 2] == player_i);
      for (int c = 0; c < NUM_CELLS; c++)
         board_full_o &= cells_i[2*c +: 2] != EMPTY;
   end
endmodule

// File: rtl/board_game_sequencer.sv
// board_game_sequencer: tic-tac-toe turn FSM with frame-aligned display copy of board, cursor and turn.
module board_game_sequencer
   import board_pkg::*;
#(
   parameter int FIRST_PLAYER   = 1,
   parameter int TIMEOUT_FRAMES = 600,
   parameter int CNT_W          = 10
) (
   input  logic        clk_25Mhz,
   input  logic        rst,
   input  logic        btn_move,
   input  logic        btn_select,
   input  logic        frame_start,
   output logic [17:0] disp_cells,
   output logic [3:0]  disp_cursor,
   output logic [1:0]  disp_turn,
   output logic        game_over,
   output logic [1:0]  winner
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
   state_t                 state_q, state_d;
   logic [2*NUM_CELLS-1:0] cells_q, cells_d, dcells_q, dcells_d;
   logic [3:0]             cursor_q, cursor_d, dcursor_q, dcursor_d;
   cell_t                  turn_q, turn_d, dturn_q, dturn_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   line_hit, board_full, tick;
   cell_t                  first, other, cur_cell;

   assign first    = cell_t'(FIRST_PLAYER[1:0]);
   assign other    = turn_q == P1 ? P2 : P1;
   assign cur_cell = cell_t'(cells_q[{cursor_q, 1'b0} +: 2]);
   assign tick     = frame_start && TIMEOUT_FRAMES != 0;

   win_detector u_win (
      .cells_i      (cells_q),
      .player_i     (turn_q),
      .line_hit_o   (line_hit),
      .board_full_o (board_full)
   );

   always_comb begin
      state_d   = state_q;
      cells_d   = cells_q;
      cursor_d  = cursor_q;
      turn_d    = turn_q;
      cnt_d     = cnt_q;
      dcells_d  = dcells_q;
      dcursor_d = dcursor_q;
      dturn_d   = dturn_q;
      // display copy samples pre-update live state, so a same-cycle write shows next frame
      if (frame_start) begin
         dcells_d  = cells_q;
         dcursor_d = cursor_q;
         dturn_d   = state_q == TURN ? turn_q : EMPTY;
      end
      case (state_q)
         IDLE: if (btn_select) state_d = TURN;
         TURN:
            if (btn_select && cur_cell == EMPTY) begin
               cells_d[{cursor_q, 1'b0} +: 2] = turn_q;
               cnt_d   = '0;
               state_d = CHECK;
            end else begin
               if (btn_move && !btn_select) cursor_d = cursor_q == 4'd8 ? 4'd0 : cursor_q + 4'd1;
               if (tick) begin
                  cnt_d  = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
                  turn_d = cnt_q == CNT_LAST ? other : turn_q;
               end
            end
         CHECK: begin
            state_d = line_hit ? WIN : board_full ? DRAW : TURN;
            if (!line_hit && !board_full) begin
               turn_d = other;
               cnt_d  = '0;
            end
         end
         default:
            if (btn_select) begin
               cells_d  = '0;
               cursor_d = '0;
               turn_d   = first;
               cnt_d    = '0;
               state_d  = TURN;
            end
      endcase
   end

   always_ff @(posedge clk_25Mhz or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cells_q   <= '0;
         cursor_q  <= '0;
         turn_q    <= first;
         cnt_q     <= '0;
         dcells_q  <= '0;
         dcursor_q <= '0;
         dturn_q   <= EMPTY;
      end else begin
         state_q   <= state_d;
         cells_q   <= cells_d;
         cursor_q  <= cursor_d;
         turn_q    <= turn_d;
         cnt_q     <= cnt_d;
         dcells_q  <= dcells_d;
         dcursor_q <= dcursor_d;
         dturn_q   <= dturn_d;
      end
   end

   assign disp_cells  = dcells_q;
   assign disp_cursor = dcursor_q;
   assign disp_turn   = dturn_q;
   assign game_over   = state_q == WIN || state_q == DRAW;
   assign winner      = state_q == WIN ? turn_q : state_q == DRAW ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_board_game_sequencer.sv
// tb_board_game_sequencer: directed game scenarios plus random play against a behavioural game model.
module tb_board_game_sequencer;
   localparam int FP = 1;
   localparam int TO = 3;
   localparam int S_IDLE = 0, S_TURN = 1, S_CHECK = 2, S_WIN = 3, S_DRAW = 4;

   logic        clk_25Mhz = 1'b0;
   logic        rst = 1'b1;
   logic        btn_move = 1'b0, btn_select = 1'b0, frame_start = 1'b0;
   logic [17:0] disp_cells;
   logic [3:0]  disp_cursor;
   logic [1:0]  disp_turn;
   logic        game_over;
   logic [1:0]  winner;

   int tests = 0, fails = 0;
   bit run = 1'b0;
   int mb[9], md[9];
   int mst, mcur, mturn, mcnt, dcur, dturn;

   board_game_sequencer #(.FIRST_PLAYER(FP), .TIMEOUT_FRAMES(TO), .CNT_W(10)) dut (
      .clk_25Mhz   (clk_25Mhz),
      .rst         (rst),
      .btn_move    (btn_move),
      .btn_select  (btn_select),
      .frame_start (frame_start),
      .disp_cells  (disp_cells),
      .disp_cursor (disp_cursor),
      .disp_turn   (disp_turn),
      .game_over   (game_over),
      .winner      (winner)
   );

   always #20 clk_25Mhz = ~clk_25Mhz;

   task automatic chk(input string n, input logic [17:0] a, input logic [17:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
      end
   endtask

   function automatic logic [17:0] pack(input int a[9]);
      logic [17:0] v = '0;
      for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(a[i]);
      return v;
   endfunction

   function automatic bit mwins(input int p);
      for (int i = 0; i < 3; i++) begin
         if (mb[3*i] == p && mb[3*i+1] == p && mb[3*i+2] == p) return 1'b1;
         if (mb[i] == p && mb[i+3] == p && mb[i+6] == p) return 1'b1;
      end
      return (mb[0] == p && mb[4] == p && mb[8] == p) || (mb[2] == p && mb[4] == p && mb[6] == p);
   endfunction

   function automatic bit mfull();
      for (int i = 0; i < 9; i++) if (mb[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic mreset();
      for (int i = 0; i < 9; i++) begin mb[i] = 0; md[i] = 0; end
      mst = S_IDLE; mcur = 0; mturn = FP; mcnt = 0; dcur = 0; dturn = 0;
   endtask

   task automatic mstep(input bit m, input bit s, input bit f);
      if (f) begin
         md = mb; dcur = mcur; dturn = (mst == S_TURN) ? mturn : 0;
      end
      case (mst)
         S_IDLE: if (s) mst = S_TURN;
         S_TURN:
            if (s && mb[mcur] == 0) begin
               mb[mcur] = mturn; mcnt = 0; mst = S_CHECK;
            end else begin
               if (m && !s) mcur = (mcur + 1) % 9;
               if (f) begin
                  mcnt++;
                  if (mcnt == TO) begin mturn = 3 - mturn; mcnt = 0; end
               end
            end
         S_CHECK:
            if (mwins(mturn)) mst = S_WIN;
            else if (mfull()) mst = S_DRAW;
            else begin mturn = 3 - mturn; mcnt = 0; mst = S_TURN; end
         default:
            if (s) begin
               for (int i = 0; i < 9; i++) mb[i] = 0;
               mcur = 0; mturn = FP; mcnt = 0; mst = S_TURN;
            end
      endcase
   endtask

   initial forever begin
      @(negedge clk_25Mhz);
      #1;
      if (run) begin
         chk("disp_cells", disp_cells, pack(md));
         chk("disp_cursor", 18'(disp_cursor), 18'(dcur));
         chk("disp_turn", 18'(disp_turn), 18'(dturn));
         chk("game_over", 18'(game_over), 18'(mst == S_WIN || mst == S_DRAW));
         chk("winner", 18'(winner), 18'(mst == S_WIN ? mturn : mst == S_DRAW ? 3 : 0));
      end
   end

   task automatic cyc(input bit m, input bit s, input bit f);
      btn_move = m; btn_select = s; frame_start = f;
      @(posedge clk_25Mhz);
      mstep(m, s, f);
      @(negedge clk_25Mhz);
      btn_move = 1'b0; btn_select = 1'b0; frame_start = 1'b0;
   endtask

   task automatic goto(input int t);
      for (int k = 0; k < 9 && mcur != t; k++) cyc(1'b1, 1'b0, 1'b0);
   endtask

   task automatic sel_at(input int c);
      goto(c);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      #5 rst = 1'b1;
      mreset();
      #1;
      chk("rst_disp_cells", disp_cells, 18'h0);
      chk("rst_disp_cursor", 18'(disp_cursor), 18'h0);
      chk("rst_disp_turn", 18'(disp_turn), 18'h0);
      chk("rst_game_over", 18'(game_over), 18'h0);
      chk("rst_winner", 18'(winner), 18'h0);
      @(posedge clk_25Mhz);
      @(negedge clk_25Mhz);
      #5 rst = 1'b0;
      @(negedge clk_25Mhz);
   endtask

   initial begin
      mreset();
      repeat (2) @(negedge clk_25Mhz);
      #5 rst = 1'b0;
      @(negedge clk_25Mhz);
      run = 1'b1;
      // P1 wins on the top row
      cyc(1'b0, 1'b1, 1'b0);
      sel_at(0); sel_at(3); sel_at(1); sel_at(4);
      goto(2);
      cyc(1'b0, 1'b1, 1'b0);
      chk("win_not_yet", 18'(game_over), 18'h0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("win_game_over", 18'(game_over), 18'h1);
      chk("win_winner", 18'(winner), 18'h1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("win_frozen", 18'(winner), 18'h1);
      // full-board draw
      cyc(1'b0, 1'b1, 1'b0);
      sel_at(0); sel_at(1); sel_at(2); sel_at(4); sel_at(3);
      sel_at(5); sel_at(7); sel_at(6); sel_at(8);
      chk("draw_winner", 18'(winner), 18'h3);
      chk("draw_game_over", 18'(game_over), 18'h1);
      // select on an occupied cell is ignored
      cyc(1'b0, 1'b1, 1'b0);
      sel_at(0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("occ_cells", disp_cells, 18'h00001);
      chk("occ_turn", 18'(disp_turn), 18'h2);
      // cursor wrap and select beating move
      goto(8);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("wrap_cursor", 18'(disp_cursor), 18'h0);
      goto(5);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("msel_cursor", 18'(disp_cursor), 18'h5);
      chk("msel_cells", disp_cells, 18'h00801);
      chk("msel_turn", 18'(disp_turn), 18'h1);
      // write coinciding with frame_start shows one frame later
      goto(4);
      cyc(1'b0, 1'b1, 1'b1);
      chk("disp_prewrite", 18'(disp_cells[9:8]), 18'h0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("disp_hold", 18'(disp_cells[9:8]), 18'h0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("disp_postwrite", 18'(disp_cells[9:8]), 18'h1);
      // timeout after three idle frames
      sel_at(8);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b1);
      chk("timeout_turn", 18'(disp_turn), 18'h2);
      chk("timeout_cells", disp_cells, 18'h20901);
      do_reset();
      // random play
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      end
      run = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
